matmul_stream_engine: RTL and testbench
=======================================

# matmul_stream_engine

Parametrised matrix-multiply engine fed by a byte stream. It accepts a frame of the dimension N, matrix A and matrix B from the UART receiver. It computes C = A·B with one multiply-accumulate per cycle and returns C as a byte stream to the UART transmitter. It generalises the fixed byte-wide multiplier: element width, maximum dimension, accumulator width and signed/unsigned mode are configurable. It also adds frame error detection and valid/ready backpressure on both sides.

## Interface
- `MAX_N`, 4: largest accepted dimension; legal range 1..15.
- `DATA_W`, 8: element width, 8 or 16. Each element is sent as DATA_W/8 bytes, LSB first.
- `ACC_W`, 18: accumulator/result width. It must be ≥ 2·DATA_W + clog2(MAX_N) for exact results; if smaller, results wrap modulo 2^ACC_W.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-low reset.
- `s_data` in 8: received byte.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: engine accepts byte; a byte transfers when `s_valid` && `s_ready`.
- `m_data` out 8: result byte.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: transmitter accepts byte.
- `signed_mode` in 1: 1 = two's-complement elements; sampled when the N byte is accepted.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse on a rejected N byte.

## Operation
- States are IDLE, LOAD_A, LOAD_B, COMPUTE, SEND.
- **IDLE**: `s_ready`=1.
  - Accepted byte N in 1..MAX_N: latch N and `signed_mode`, go to LOAD_A.
  - N=0 or N>MAX_N: byte consumed, `err` pulses the next cycle, stay in IDLE.
- **LOAD_A / LOAD_B**: `s_ready`=1.
  - Receive N·N elements in row-major order; bytes are assembled LSB first.
  - Element (r,c) is stored at address r·MAX_N+c, a constant stride.
  - After the last byte of A go to LOAD_B; after the last byte of B go to COMPUTE.
- **COMPUTE**: `s_ready`=0.
  - For each (i,j) in row-major order, run N MAC cycles (acc += A[i][k]·B[k][j], k=0..N-1), then one store cycle that writes acc to C[i][j] and clears acc.
  - Products are sign-extended in signed mode and zero-extended otherwise.
  - Duration is N·N·(N+1) cycles, then go to SEND.
- **SEND**:
  - Emit C row-major, each result as OUT_BYTES = ceil(ACC_W/8) bytes, LSB first.
  - The upper bits are sign-extended in signed mode and zero-extended otherwise.
  - After the last byte is accepted, go to IDLE.
- Bytes presented while `s_ready`=0 are not consumed; upstream holds them.

## Timing
- Reset values: `s_ready`=0 while `rst` is low, and 1 on the first cycle after release (state IDLE). `m_valid`=0, `m_data`=0, `busy`=0, `err`=0. All counters and the accumulator are 0. Array contents are undefined.
- Reset asserted in any state aborts the frame immediately. No partial output is emitted after release.
- COMPUTE starts the cycle after the final B byte handshake. The first `m_valid` rises N·N·(N+1)+1 cycles after that handshake (37 for N=3).
- While `m_valid`=1 and `m_ready`=0, `m_data` holds stable. `m_valid` never drops without a handshake.
- With `m_ready` tied high, SEND emits one byte per cycle.
- `signed_mode` changes after the N byte have no effect on the current frame.
- `err` and the return to IDLE happen together; the next byte is treated as a new N.

## Structure
- Package `matmul_pkg` holds:
  - the state enum;
  - the OUT_BYTES and IN_BYTES localparam functions;
  - the clog2 helper.
- Sub-module `matmul_mac`, one instance:
  - ports: operands, signed flag, clear and enable;
  - registered ACC_W accumulator with one-cycle update.
- Matrices A, B and C are register arrays of MAX_N² entries in the top.

## Test plan
- **3×3 unsigned, no backpressure.** Stimulus: N=03, A=01..09, B=09..01. Required: C=30,24,18,84,69,54,138,114,90, giving 27 bytes starting 1E 00 00 18 00 00. First `m_valid` 37 cycles after the last B byte.
- **1×1 signed vs unsigned.** Stimulus: A=FF, B=02. Required: signed gives FE FF FF; unsigned gives FE 01 00.
- **Bad N.** Stimulus: N=05 with MAX_N=4, then N=00. Required: one `err` pulse each, `s_ready` stays 1, `busy` stays 0. A following valid 2×2 frame (A=1,2,3,4; B=5,6,7,8) returns 19,22,43,50.
- **Output backpressure.** Stimulus: drop `m_ready` for 10 cycles mid-result. Required: `m_data` and `m_valid` are stable and no byte is lost or duplicated.
- **Reset mid-LOAD_B.** Stimulus: assert `rst` low mid-LOAD_B. Required: all outputs immediately at reset values. A subsequent full 3×3 frame produces the correct 27 bytes.
- **DATA_W=16, MAX_N=2, ACC_W=33.** Stimulus: A=B=identity scaled by FFFF. Required: diagonal results FFFE0001 in 5 bytes (01 00 FE FF 00).

Source files
------------

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared states, sizing helpers for the matmul stream engine
package matmul_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD_A  = 3'd1;
    localparam state_t ST_LOAD_B  = 3'd2;
    localparam state_t ST_COMPUTE = 3'd3;
    localparam state_t ST_SEND    = 3'd4;

    // Smallest r with 2**r >= v
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bytes per input element
    function automatic int in_bytes(input int data_w);
        return (data_w + 7) / 8;
    endfunction

    // Bytes per emitted result
    function automatic int out_bytes(input int acc_w);
        return (acc_w + 7) / 8;
    endfunction

endpackage

// File: rtl/matmul_stream_engine_mac.sv
// rtl/matmul_stream_engine_mac.sv - single multiply-accumulate lane with registered accumulator
module matmul_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              signed_mode,
    input  logic              clear,
    input  logic              enable,
    output logic [ACC_W-1:0]  acc
);

    // Product is formed wide enough to hold both the full product and the accumulator
    localparam int PW = (ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod;

    // Extend operands per element mode; the modulo-2**PW product is then exact for both modes
    always_comb begin
        if (signed_mode) begin
            a_ext = PW'($signed(a));
            b_ext = PW'($signed(b));
        end else begin
            a_ext = PW'(a);
            b_ext = PW'(b);
        end
        prod = a_ext * b_ext;
    end

    // Accumulate one product per enabled cycle; clear wins over enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + prod[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/matmul_stream_engine.sv
// rtl/matmul_stream_engine.sv - byte-stream fed C = A*B engine with valid/ready on both sides
module matmul_stream_engine
    import matmul_pkg::*;
#(
    parameter int MAX_N  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    input  logic       signed_mode,
    output logic       busy,
    output logic       err
);

    localparam int IN_BYTES  = in_bytes(DATA_W);
    localparam int OUT_BYTES = out_bytes(ACC_W);
    localparam int OW        = OUT_BYTES * 8;
    localparam int DEPTH     = MAX_N * MAX_N;
    localparam int AW        = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    // k runs 0..N inclusive (N is the store step), so counters hold MAX_N itself
    localparam int CW        = clog2(MAX_N + 1);
    localparam int MX_BYTES  = (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES;
    localparam int BCW       = (clog2(MX_BYTES) < 1) ? 1 : clog2(MX_BYTES);

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     n;
    logic              sgn;
    logic [CW-1:0]     r;
    logic [CW-1:0]     c;
    logic [CW-1:0]     k;
    logic [BCW-1:0]    bcnt;
    logic [DATA_W-1:0] elem_buf;
    logic [DATA_W-1:0] elem_next;

    logic [DATA_W-1:0] a_mem [DEPTH];
    logic [DATA_W-1:0] b_mem [DEPTH];
    logic [ACC_W-1:0]  c_mem [DEPTH];

    logic              fire_in;
    logic              fire_out;
    logic              n_ok;
    logic              last_in_byte;
    logic              last_out_byte;
    logic              last_col;
    logic              last_row;
    logic              store;
    logic              loading;
    logic              rc_step;
    logic [CW-1:0]     k_rd;
    logic [AW-1:0]     rc_addr;
    logic [AW-1:0]     a_addr;
    logic [AW-1:0]     b_addr;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  c_sel;
    logic [OW-1:0]     c_ext;
    logic [7:0]        m_byte;

    // Handshake qualifiers, position flags and array addresses
    always_comb begin
        fire_in       = s_valid && s_ready;
        fire_out      = m_valid && m_ready;
        n_ok          = (s_data != 8'd0) && (s_data <= 8'(MAX_N));
        last_in_byte  = (bcnt == BCW'(IN_BYTES - 1));
        last_out_byte = (bcnt == BCW'(OUT_BYTES - 1));
        last_col      = (c == n - CW'(1));
        last_row      = (r == n - CW'(1));
        store         = (k == n);
        loading       = (state == ST_LOAD_A) || (state == ST_LOAD_B);
        // k == N is the store step; keep the read address in range there
        k_rd          = store ? '0 : k;
        rc_addr       = AW'(r) * AW'(MAX_N) + AW'(c);
        a_addr        = AW'(r) * AW'(MAX_N) + AW'(k_rd);
        b_addr        = AW'(k_rd) * AW'(MAX_N) + AW'(c);
        rc_step       = (loading && fire_in && last_in_byte) ||
                        ((state == ST_COMPUTE) && store) ||
                        ((state == ST_SEND) && fire_out && last_out_byte);
    end

    // Merge the incoming byte into the partially assembled element, LSB first
    always_comb begin
        elem_next = elem_buf;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (bcnt == BCW'(i)) begin
                elem_next[i*8 +: 8] = s_data;
            end
        end
    end

    // Frame sequencing: header, A, B, compute, drain results
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (fire_in && n_ok) state_next = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                if (fire_in && last_in_byte && last_row && last_col) state_next = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                if (fire_in && last_in_byte && last_row && last_col) state_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (store && last_row && last_col) state_next = ST_SEND;
            end
            ST_SEND: begin
                if (fire_out && last_out_byte && last_row && last_col) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Control registers; s_ready is registered from the next state so it stays low in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            n        <= '0;
            sgn      <= 1'b0;
            r        <= '0;
            c        <= '0;
            k        <= '0;
            bcnt     <= '0;
            elem_buf <= '0;
            s_ready  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state   <= state_next;
            s_ready <= (state_next == ST_IDLE) || (state_next == ST_LOAD_A) ||
                       (state_next == ST_LOAD_B);
            err     <= 1'b0;

            if (state == ST_IDLE && fire_in) begin
                if (n_ok) begin
                    n    <= s_data[CW-1:0];
                    sgn  <= signed_mode;
                    r    <= '0;
                    c    <= '0;
                    k    <= '0;
                    bcnt <= '0;
                end else begin
                    err <= 1'b1;
                end
            end

            if (loading && fire_in) begin
                elem_buf <= elem_next;
                bcnt     <= last_in_byte ? '0 : bcnt + BCW'(1);
            end

            if (state == ST_COMPUTE) begin
                k <= store ? '0 : k + CW'(1);
            end

            if (state == ST_SEND && fire_out) begin
                bcnt <= last_out_byte ? '0 : bcnt + BCW'(1);
            end

            if (rc_step) begin
                if (last_col) begin
                    c <= '0;
                    r <= last_row ? '0 : r + CW'(1);
                end else begin
                    c <= c + CW'(1);
                end
            end
        end
    end

    // Matrix storage; contents are don't-care until written by the current frame
    always_ff @(posedge clk) begin
        if (state == ST_LOAD_A && fire_in && last_in_byte) a_mem[rc_addr] <= elem_next;
        if (state == ST_LOAD_B && fire_in && last_in_byte) b_mem[rc_addr] <= elem_next;
        if (state == ST_COMPUTE && store) c_mem[rc_addr] <= acc;
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk         (clk),
        .rst         (rst),
        .a           (a_mem[a_addr]),
        .b           (b_mem[b_addr]),
        .signed_mode (sgn),
        .clear       ((state == ST_COMPUTE) && store),
        .enable      ((state == ST_COMPUTE) && !store),
        .acc         (acc)
    );

    // Output byte is a pure function of held counters, so it is stable under backpressure
    always_comb begin
        c_sel  = c_mem[rc_addr];
        c_ext  = sgn ? OW'($signed(c_sel)) : OW'(c_sel);
        m_byte = 8'd0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (bcnt == BCW'(i)) begin
                m_byte = c_ext[i*8 +: 8];
            end
        end
        m_valid = (state == ST_SEND);
        m_data  = (state == ST_SEND) ? m_byte : 8'd0;
        busy    = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// tb/tb_matmul_stream_engine.sv - scoreboard bench for matmul_stream_engine
module tb_matmul_stream_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] s_data, m_data;
    logic       s_valid, s_ready, m_valid, m_ready, signed_mode, busy, err;

    logic [7:0] s_data2, m_data2;
    logic       s_valid2, s_ready2, m_valid2, m_ready2, signed_mode2, busy2, err2;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];
    logic [7:0] frame[$];

    int c_3x3 [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int c_2x2 [4] = '{19, 22, 43, 50};

    logic       held;
    logic [7:0] held_data;

    always #5 clk = ~clk;

    matmul_stream_engine #(.MAX_N(4), .DATA_W(8), .ACC_W(18)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .signed_mode(signed_mode), .busy(busy), .err(err)
    );

    matmul_stream_engine #(.MAX_N(2), .DATA_W(16), .ACC_W(33)) dut2 (
        .clk(clk), .rst(rst),
        .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
        .signed_mode(signed_mode2), .busy(busy2), .err(err2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic push_val(input bit which, input longint v, input int nb);
        for (int b = 0; b < nb; b++) begin
            if (!which) exp_q.push_back(8'((v >> (8 * b)) & 8'hFF));
            else        exp2_q.push_back(8'((v >> (8 * b)) & 8'hFF));
        end
    endtask

    // Called at #1 after a rising edge; returns #1 after the handshake edge
    task automatic send_byte(input bit which, input logic [7:0] b);
        int t;
        t = 0;
        if (!which) begin
            s_data = b; s_valid = 1'b1;
            while (!s_ready && t < 2000) begin @(posedge clk); #1; t++; end
        end else begin
            s_data2 = b; s_valid2 = 1'b1;
            while (!s_ready2 && t < 2000) begin @(posedge clk); #1; t++; end
        end
        if (t >= 2000) begin
            checks++;
            $display("FAIL send_timeout: s_ready low for %0d cycles, required high", t);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_valid2 = 1'b0;
    endtask

    task automatic send_frame(input bit which);
        foreach (frame[i]) send_byte(which, frame[i]);
    endtask

    task automatic wait_drain(input bit which);
        int t;
        t = 0;
        if (!which) while ((exp_q.size() != 0 || busy) && t < 2000) begin @(posedge clk); #1; t++; end
        else        while ((exp2_q.size() != 0 || busy2) && t < 2000) begin @(posedge clk); #1; t++; end
        check("drain_in_time", 64'(t < 2000), 64'd1);
    endtask

    task automatic build_3x3;
        frame.delete();
        frame.push_back(8'h03);
        for (int i = 1; i <= 9; i++) frame.push_back(8'(i));
        for (int i = 9; i >= 1; i--) frame.push_back(8'(i));
    endtask

    task automatic expect_3x3;
        for (int i = 0; i < 9; i++) push_val(1'b0, longint'(c_3x3[i]), 3);
    endtask

    // Scoreboard monitor for the default instance, plus hold-stability under backpressure
    always @(negedge clk) begin
        if (rst) begin
            if (held) begin
                check("bp_valid_stable", 64'(m_valid), 64'd1);
                check("bp_data_stable", 64'(m_data), 64'(held_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_byte: got %0h required none", m_data);
                end else begin
                    check("out_byte", 64'(m_data), 64'(exp_q.pop_front()));
                end
            end
            held      <= m_valid && !m_ready;
            held_data <= m_data;
        end else begin
            held <= 1'b0;
        end
    end

    // Scoreboard monitor for the wide-element instance
    always @(negedge clk) begin
        if (rst && m_valid2 && m_ready2) begin
            if (exp2_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_byte_w16: got %0h required none", m_data2);
            end else begin
                check("out_byte_w16", 64'(m_data2), 64'(exp2_q.pop_front()));
            end
        end
    end

    initial begin
        int cnt;
        s_data = 8'd0; s_valid = 1'b0; m_ready = 1'b1; signed_mode = 1'b0;
        s_data2 = 8'd0; s_valid2 = 1'b0; m_ready2 = 1'b1; signed_mode2 = 1'b0;

        // Reset values
        #2 rst = 1'b0;
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_s_ready", 64'(s_ready), 64'd1);

        // 3x3 unsigned, no backpressure, with latency measured from the handshake cycle
        build_3x3();
        expect_3x3();
        send_frame(1'b0);
        check("compute_s_ready_low", 64'(s_ready), 64'd0);
        cnt = 1;
        while (!m_valid && cnt < 200) begin @(posedge clk); #1; cnt++; end
        check("first_valid_latency", 64'(cnt), 64'd37);
        wait_drain(1'b0);

        // 1x1 signed; signed_mode dropped after the N byte must not matter
        signed_mode = 1'b1;
        send_byte(1'b0, 8'h01);
        signed_mode = 1'b0;
        send_byte(1'b0, 8'hFF);
        send_byte(1'b0, 8'h02);
        push_val(1'b0, 64'hFFFFFE, 3);
        wait_drain(1'b0);

        // 1x1 unsigned
        frame = {8'h01, 8'hFF, 8'h02};
        push_val(1'b0, 64'h0001FE, 3);
        send_frame(1'b0);
        wait_drain(1'b0);

        // Bad N values
        send_byte(1'b0, 8'h05);
        check("err_n5", 64'(err), 64'd1);
        check("err_n5_s_ready", 64'(s_ready), 64'd1);
        check("err_n5_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("err_n5_pulse_end", 64'(err), 64'd0);
        send_byte(1'b0, 8'h00);
        check("err_n0", 64'(err), 64'd1);
        check("err_n0_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("err_n0_pulse_end", 64'(err), 64'd0);

        // Valid 2x2 after errors
        frame = {8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int i = 0; i < 4; i++) push_val(1'b0, longint'(c_2x2[i]), 3);
        send_frame(1'b0);
        wait_drain(1'b0);

        // Output backpressure for 10 cycles mid-result
        build_3x3();
        expect_3x3();
        send_frame(1'b0);
        cnt = 0;
        while (!m_valid && cnt < 200) begin @(posedge clk); #1; cnt++; end
        repeat (4) begin @(posedge clk); #1; end
        m_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        m_ready = 1'b1;
        wait_drain(1'b0);

        // Reset while loading B, then a full frame
        frame = {8'h03};
        for (int i = 1; i <= 9; i++) frame.push_back(8'(i));
        for (int i = 0; i < 4; i++) frame.push_back(8'h07);
        send_frame(1'b0);
        check("mid_b_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("abort_s_ready", 64'(s_ready), 64'd0);
        check("abort_m_valid", 64'(m_valid), 64'd0);
        check("abort_m_data", 64'(m_data), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_release_s_ready", 64'(s_ready), 64'd1);
        build_3x3();
        expect_3x3();
        send_frame(1'b0);
        wait_drain(1'b0);

        // DATA_W=16, MAX_N=2, ACC_W=33: identity scaled by FFFF
        frame = {8'h02,
                 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF,
                 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        push_val(1'b1, 64'hFFFE0001, 5);
        push_val(1'b1, 64'h0, 5);
        push_val(1'b1, 64'h0, 5);
        push_val(1'b1, 64'hFFFE0001, 5);
        send_frame(1'b1);
        wait_drain(1'b1);

        check("queue_empty", 64'(exp_q.size() + exp2_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
